// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin (LSB first) with borrow-out and signed overflow.
// Ports: clk, rst (async, active-high); start, A, B, Bin request and operands;
// busy high during the WIDTH shift cycles, done pulses one cycle with new D, Bout, V.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_nxt;
  logic [WIDTH-2:0] r_sr;
  logic [CW-1:0] cnt;
  logic br, d, br_nxt, last;
  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last   = cnt == CW'(WIDTH - 1);
  assign r_nxt  = {d, r_sr};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
                state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  always_comb begin
    busy = state == SHIFT;
    done = state == DONE;
  end
  // On the final edge the operand LSBs are the captured MSBs, so V comes straight from the cell.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
      V    <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr <= A;
      b_sr <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_nxt[WIDTH-1:1];
      br   <= br_nxt;
      cnt  <= cnt + 1'b1;
      if (last) begin
        D    <= r_nxt;
        Bout <= br_nxt;
        V    <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, Bin = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic busy, done, Bout, V;
  logic [7:0] D;
  int checks = 0, errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .D(D), .Bout(Bout), .V(V)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model(input int a, input int b, input int bin);
    int diff, sd;
    logic vv, bo;
    logic [7:0] dd;
    diff = a - b - bin;
    sd   = (a >= 128 ? a - 256 : a) - (b >= 128 ? b - 256 : b) - bin;
    vv   = sd < -128 || sd > 127;
    bo   = diff < 0;
    dd   = 8'(diff);
    return {vv, bo, dd};
  endfunction

  // Issues one start pulse, scrambles the inputs after capture, waits (bounded) for done.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int lat, output int bcnt);
    @(posedge clk); #1;
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, D, Bout, V} !== 12'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b D=%h Bout=%b V=%b, want all 0", busy, done, D, Bout, V);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [7:0] va [6] = '{8'd10, 8'd3, 8'h80, 8'h7F, 8'h00, 8'hFF};
    logic [7:0] vb [6] = '{8'd3, 8'd10, 8'h01, 8'hFF, 8'h00, 8'hFF};
    logic       vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [9:0] want [6] = '{{2'b00, 8'h07}, {2'b01, 8'hF9}, {2'b10, 8'h7F},
                             {2'b11, 8'h80}, {2'b01, 8'hFF}, {2'b00, 8'h00}};
    int lat, bcnt;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vc[i], lat, bcnt);
      checks++;
      if (lat !== 8 || bcnt !== 8) begin
        errors++;
        $display("FAIL directed_latency[%0d]: lat=%0d busy_cycles=%0d, want 8/8", i, lat, bcnt);
      end
      checks++;
      if ({V, Bout, D} !== want[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: V=%b Bout=%b D=%h, want V=%b Bout=%b D=%h",
                 i, V, Bout, D, want[i][9], want[i][8], want[i][7:0]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_busy_at_done[%0d]: busy=%b, want 0", i, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL directed_done_width[%0d]: done=%b one cycle later, want 0", i, done);
      end
    end
  endtask

  task automatic test_random;
    int lat, bcnt;
    logic [7:0] a, b;
    logic c;
    logic [9:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = model(int'(a), int'(b), int'(c));
      do_op(a, b, c, lat, bcnt);
      checks++;
      if (lat !== 8 || bcnt !== 8 || {V, Bout, D} !== exp) begin
        errors++;
        $display("FAIL random[%0d] %h-%h-%b: lat=%0d busy=%0d V=%b Bout=%b D=%h, want 8/8 V=%b Bout=%b D=%h",
                 i, a, b, c, lat, bcnt, V, Bout, D, exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] e1, e2;
    int n, gap;
    e1 = model(200, 77, 1);
    e2 = model(5, 9, 0);
    @(posedge clk); #1;
    A = 8'd200; B = 8'd77; Bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    A = 8'd5; B = 8'd9; Bin = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 8 || {V, Bout, D} !== e1) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d V=%b Bout=%b D=%h, want 8 V=%b Bout=%b D=%h",
               n, V, Bout, D, e1[9], e1[8], e1[7:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b, want 0/0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || D !== e1[7:0]) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%b D=%h, want 1 D=%h", busy, D, e1[7:0]);
    end
    gap = 2;
    while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
    start = 1'b0;
    checks++;
    if (gap !== 10 || {V, Bout, D} !== e2) begin
      errors++;
      $display("FAIL b2b_second: period=%0d V=%b Bout=%b D=%h, want 10 V=%b Bout=%b D=%h",
               gap, V, Bout, D, e2[9], e2[8], e2[7:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, seen;
    @(posedge clk); #1;
    A = 8'd9; B = 8'd1; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, D, Bout, V} !== 12'h0) begin
      errors++;
      $display("FAIL reset_async: busy=%b done=%b D=%h Bout=%b V=%b, want all 0", busy, done, D, Bout, V);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0 || D !== 8'h00) begin
      errors++;
      $display("FAIL reset_no_done: done_pulses=%0d D=%h, want 0 D=00", seen, D);
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    do_op(8'd5, 8'd2, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 8 || D !== 8'h03 || Bout !== 1'b0 || V !== 1'b0) begin
      errors++;
      $display("FAIL reset_then_op: lat=%0d D=%h Bout=%b V=%b, want 8 D=03 Bout=0 V=0", lat, D, Bout, V);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b, want not both 1", busy, done);
      end
    end

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
